seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector for the single-bit input stream.
- Pattern, length and overlap mode are run-time configurable.
- z is a Mealy output, asserted in the same cycle the final pattern bit is presented.
- A saturating counter accumulates matches.
- Reset defaults reproduce the fixed 01001 detector, so it is a drop-in upgrade for the existing hard-coded FSM detectors in the EPIS exercise set.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- LEN_W, 4, width of pat_len; must hold MAX_LEN
- CNT_W, 8, width of match_count
- RST_PATTERN, 8'b00001001, pattern register value after reset
- RST_LEN, 5, length register value after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- x  in  1  serial data bit
- valid_in  in  1  x is sampled only when 1
- cfg_load  in  1  latch pattern, pat_len and overlap; clears detection state
- pattern  in  MAX_LEN  pattern bits; bit [len-1] is the first bit received, bit 0 the last
- pat_len  in  LEN_W  pattern length, legal range 1..MAX_LEN
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match
- cnt_clr  in  1  synchronous clear of match_count
- z  out  1  match indication (combinational from registered state, x and valid_in)
- match_count  out  CNT_W  saturating count of matches
- fill  out  LEN_W  number of valid history bits held, saturating at MAX_LEN

## Operation
Internal registers:
- hist[MAX_LEN-1:0]: shift history; new bit enters at bit 0.
- fill counter.
- Config registers: pat_r, len_r, ovl_r.

Match condition (combinational):
- Candidate cand = {hist[MAX_LEN-2:0], x}.
- z = valid_in & !cfg_load & (len_r in 1..MAX_LEN) & (fill+1 ≥ len_r) & ((cand ^ pat_r) masked to the low len_r bits == 0).

Per rising edge, in priority order:
1. cfg_load=1:
   - pat_r←pattern, len_r←pat_len, ovl_r←overlap.
   - hist←0, fill←0, match_count←0.
   - x is ignored.
2. valid_in=1 and z=1:
   - match_count increments, saturating at 2^CNT_W-1.
   - If ovl_r=1: hist←cand, fill←min(fill+1, MAX_LEN).
   - If ovl_r=0: hist←0, fill←0.
3. valid_in=1 and z=0: hist←cand, fill←min(fill+1, MAX_LEN).
4. valid_in=0: hist and fill hold; z=0.

cnt_clr:
- Clears match_count on the edge.
- If cnt_clr and a match coincide, the result is 0; the clear wins.
- cfg_load takes precedence over everything.

Illegal lengths:
- pat_len=0 or pat_len>MAX_LEN is latched as given, but z stays 0 permanently until the next legal load.
- History shifting continues normally.

## Timing
Reset (reset=0), asynchronous:
- hist=0, fill=0, match_count=0.
- pat_r=RST_PATTERN, len_r=RST_LEN, ovl_r=1.
- z=0 while reset is asserted.

Latency:
- z is valid in the same cycle as the final matching bit (Mealy, zero latency).
- match_count reflects the match after that clock edge (1 cycle).

Other cycle-level rules:
- Config takes effect on the cycle after cfg_load. A bit presented during the cfg_load cycle is discarded.
- Reset deasserted mid-stream: detection restarts with empty history. A partial prefix is never remembered across reset or cfg_load.
- fill saturation: once fill=MAX_LEN it holds. The oldest bit shifts out of hist.
- Counter saturation: match_count stays at all-ones and never wraps.
- valid_in gaps do not break a sequence. Only valid bits count.

## Test plan
- Reset defaults, stream 0,1,0,0,1 → z=1 only on the 5th bit; match_count=1 afterwards.
- Default config, stream 0,1,0,0,1,0,0,1 (overlap=1) → z on bits 5 and 8; match_count=2.
- Load pattern=0101, pat_len=4:
  - overlap=1, stream 0,1,0,1,0,1 → z on bits 4 and 6.
  - overlap=0, same stream → z on bit 4 only.
  - overlap=0, then 0,1 more → z on bit 8.
- Default pattern, stream 0,1,0 with valid_in=0 for 3 cycles, then 0,1 → z on the final 1. No z during the gap.
- CNT_W=2, ten matches of pat_len=1 pattern 1 → match_count saturates at 3; cnt_clr coincident with a match → 0.
- Stream 0,1,0,0 then assert reset for 1 cycle, then x=1 → z=0 (history cleared).
- pat_len=0 load → z never asserts; fill still increments on valid bits.

Source files
------------

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with a Mealy match output,
// optional overlapping matches and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b00001001,
    parameter logic [LEN_W-1:0]   RST_LEN     = 4'd5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               valid_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               len_ok;
    logic               fill_ok;
    logic               z_int;

    always_comb begin
        cand = {hist_q[MAX_LEN-2:0], x};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        len_ok   = (len_q != '0) && (len_q <= MAX_FILL);
        fill_ok  = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
        fill_inc = (fill_q == MAX_FILL) ? fill_q : fill_q + LEN_W'(1);
        // Gating with reset keeps z low while the registers are held in reset.
        z_int    = reset & valid_in & ~cfg_load & len_ok & fill_ok
                   & (((cand ^ pat_q) & mask) == '0);
    end

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        len_d  = len_q;
        fill_d = fill_q;
        ovl_d  = ovl_q;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            pat_d  = pattern;
            len_d  = pat_len;
            ovl_d  = overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else begin
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (z_int && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (valid_in) begin
                // Non-overlapping mode restarts the history after every match.
                if (z_int && !ovl_q) begin
                    hist_d = '0;
                    fill_d = '0;
                end else begin
                    hist_d = cand;
                    fill_d = fill_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            pat_q  <= RST_PATTERN;
            len_q  <= RST_LEN;
            fill_q <= '0;
            ovl_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            fill_q <= fill_d;
            ovl_q  <= ovl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z           = z_int;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic, checked
// against a queue-based model of the valid bit stream.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       valid_in = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic       overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       z, z_s;
    logic [7:0] match_count;
    logic [1:0] cnt_s;
    logic [3:0] fill, fill_s;

    int errors = 0;
    int checks = 0;

    bit         q[$];
    logic [7:0] pat_m;
    int         len_m;
    bit         ovl_m;
    int         cnt_m;
    int         cnt_sm;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .x(x), .valid_in(valid_in), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .z(z), .match_count(match_count), .fill(fill)
    );

    seq_detector_param #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .x(x), .valid_in(valid_in), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .z(z_s), .match_count(cnt_s), .fill(fill_s)
    );

    always #5 clk = ~clk;

    function automatic bit model_z(bit xb, bit v, bit ld);
        bit b;
        if (!v || ld) return 1'b0;
        if (len_m < 1 || len_m > MAX_LEN) return 1'b0;
        if (q.size() + 1 < len_m) return 1'b0;
        for (int i = 0; i < len_m; i++) begin
            b = (i == 0) ? xb : q[q.size() - i];
            if (b != pat_m[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pat_m  = 8'b00001001;
        len_m  = 5;
        ovl_m  = 1'b1;
        cnt_m  = 0;
        cnt_sm = 0;
    endtask

    task automatic apply(input bit xb, input bit v, input bit ld, input logic [7:0] pat,
                         input logic [3:0] len, input bit ovl, input bit clr, input string tag);
        bit ez;
        @(negedge clk);
        x = xb; valid_in = v; cfg_load = ld; pattern = pat; pat_len = len;
        overlap = ovl; cnt_clr = clr;
        #1;
        ez = model_z(xb, v, ld);
        chk({tag, "_z"}, 32'(z), 32'(ez));
        chk({tag, "_zs"}, 32'(z_s), 32'(ez));
        chk({tag, "_fill"}, 32'(fill), 32'(q.size()));
        chk({tag, "_cnt"}, 32'(match_count), 32'(cnt_m));
        chk({tag, "_cnts"}, 32'(cnt_s), 32'(cnt_sm));
        if (ld) begin
            pat_m = pat; len_m = int'(len); ovl_m = ovl;
            q.delete(); cnt_m = 0; cnt_sm = 0;
        end else begin
            if (clr) begin
                cnt_m = 0; cnt_sm = 0;
            end else if (ez) begin
                if (cnt_m < 255) cnt_m++;
                if (cnt_sm < 3) cnt_sm++;
            end
            if (v) begin
                if (ez && !ovl_m) q.delete();
                else begin
                    q.push_back(xb);
                    if (q.size() > MAX_LEN) void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic bitv(input bit xb, input string tag);
        apply(xb, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic gap(input string tag);
        apply(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic loadc(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        apply(1'($urandom_range(0, 1)), 1'b1, 1'b1, pat, len, ovl, 1'b0, "load");
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int i = 0; i < n; i++) bitv(bits[n-1-i], tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b1; x = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_zs", 32'(z_s), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        model_reset();
        @(negedge clk);
        valid_in = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        int r;
        model_reset();

        do_reset();
        feed(16'b01001, 5, "dflt");
        gap("dflt_gap");
        chk("dflt_cnt1", 32'(match_count), 32'd1);

        do_reset();
        feed(16'b01001001, 8, "ovl");
        gap("ovl_gap");
        chk("ovl_cnt2", 32'(match_count), 32'd2);

        loadc(8'b0101, 4'd4, 1'b1);
        feed(16'b010101, 6, "p4o");
        gap("p4o_gap");
        chk("p4o_cnt", 32'(match_count), 32'd2);
        loadc(8'b0101, 4'd4, 1'b0);
        feed(16'b010101, 6, "p4n");
        feed(16'b01, 2, "p4n2");
        gap("p4n_gap");
        chk("p4n_cnt", 32'(match_count), 32'd2);

        do_reset();
        feed(16'b010, 3, "vgap_a");
        for (int i = 0; i < 3; i++) gap("vgap");
        feed(16'b01, 2, "vgap_b");
        gap("vgap_end");
        chk("vgap_cnt", 32'(match_count), 32'd1);

        loadc(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 10; i++) bitv(1'b1, "sat");
        gap("sat_gap");
        chk("sat_cnts", 32'(cnt_s), 32'd3);
        chk("sat_cnt", 32'(match_count), 32'd10);
        apply(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "clr_match");
        gap("clr_gap");
        chk("clr_cnts", 32'(cnt_s), 32'd0);

        do_reset();
        feed(16'b0100, 4, "rmid");
        do_reset();
        bitv(1'b1, "rmid_after");

        loadc(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 12; i++) bitv(1'($urandom_range(0, 1)), "len0");
        loadc(8'hFF, 4'd9, 1'b1);
        for (int i = 0; i < 12; i++) bitv(1'b1, "len9");
        loadc(8'b10110010, 4'd8, 1'b1);
        feed(16'b1011001010110010, 16, "len8");

        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 199);
            if (r < 4)
                loadc(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            else if (r < 10)
                loadc(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            else if (r < 14)
                apply(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "rnd_clr");
            else if (r < 40)
                gap("rnd_gap");
            else if (r == 199)
                do_reset();
            else
                bitv(1'($urandom_range(0, 1)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
